// File: rtl/neck_judge_multi.sv
// Welding neck detector: qualifies a derivative signature, opens the IGBT for a
// bounded cut window, then enforces a hold-off before re-arming.
module neck_judge_multi #(
  parameter int unsigned DW       = 13,
  parameter int unsigned TW       = 23,
  parameter int unsigned QUAL_N   = 1,
  parameter int unsigned CUT_MAX  = 100000,
  parameter int unsigned MIN_CUT  = 2000,
  parameter int unsigned HOLD_MAX = 5000000,
  parameter int unsigned CW       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctl_switch,
  input  logic                 en_judge,
  input  logic                 end_en,
  input  logic signed [DW-1:0] first_order_data,
  input  logic signed [DW-1:0] second_order_data,
  input  logic signed [DW-1:0] third_order_data,
  input  logic signed [DW-1:0] st_d1_min,
  input  logic signed [DW-1:0] st_d2_min,
  input  logic signed [DW-1:0] st_d3_lo,
  input  logic signed [DW-1:0] st_d3_hi,
  input  logic signed [DW-1:0] end_d1_min,
  input  logic signed [DW-1:0] end_d2_max,
  output logic                 power_switch,
  output logic [1:0]           state,
  output logic [CW-1:0]        neck_cnt,
  output logic                 end_pulse,
  output logic                 timeout_pulse
);

  localparam int unsigned QW = 4;

  // Elaboration-time guards: timers must never wrap, qualify count must fit.
  if (64'(CUT_MAX) >= (64'd1 << TW) || 64'(HOLD_MAX) >= (64'd1 << TW)) begin : g_bad_tw
    $error("TW too narrow for CUT_MAX/HOLD_MAX");
  end
  if (QUAL_N < 1 || QUAL_N > 15) begin : g_bad_qual
    $error("QUAL_N out of range 1..15");
  end
  if (MIN_CUT < 1 || MIN_CUT > CUT_MAX) begin : g_bad_min
    $error("MIN_CUT out of range 1..CUT_MAX");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_CUT   = 2'b10,
    S_HOLD  = 2'b11
  } state_t;

  state_t         st;
  logic [TW-1:0]  cut_cnt;
  logic [TW-1:0]  hold_cnt;
  logic [QW-1:0]  qual_cnt;
  logic           start_c;
  logic           end_c;
  logic           early_c;

  assign start_c = (first_order_data  > st_d1_min) && (second_order_data > st_d2_min) &&
                   (third_order_data  > st_d3_lo)  && (third_order_data  < st_d3_hi);
  assign end_c   = (first_order_data  > end_d1_min) && (second_order_data < end_d2_max);
  assign early_c = end_en && en_judge && end_c && (cut_cnt >= TW'(MIN_CUT - 1));

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= S_IDLE;
      power_switch  <= 1'b0;
      neck_cnt      <= '0;
      end_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      cut_cnt       <= '0;
      hold_cnt      <= '0;
      qual_cnt      <= '0;
    end else begin
      end_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      if (!ctl_switch) begin
        st           <= S_IDLE;
        power_switch <= 1'b0;
        cut_cnt      <= '0;
        hold_cnt     <= '0;
        qual_cnt     <= '0;
      end else begin
        unique case (st)
          S_IDLE: st <= S_ARMED;
          S_ARMED: begin
            if (en_judge) begin
              if (!start_c) begin
                qual_cnt <= '0;
              end else if (qual_cnt == QW'(QUAL_N - 1)) begin
                st           <= S_CUT;
                power_switch <= 1'b1;
                cut_cnt      <= '0;
                qual_cnt     <= '0;
                if (neck_cnt != {CW{1'b1}}) neck_cnt <= neck_cnt + CW'(1);
              end else begin
                qual_cnt <= qual_cnt + QW'(1);
              end
            end
          end
          S_CUT: begin
            cut_cnt <= cut_cnt + TW'(1);
            // An end signature wins over a coincident timeout.
            if (early_c || cut_cnt == TW'(CUT_MAX - 1)) begin
              st            <= S_HOLD;
              power_switch  <= 1'b0;
              hold_cnt      <= '0;
              end_pulse     <= early_c;
              timeout_pulse <= !early_c;
            end
          end
          S_HOLD: begin
            if (hold_cnt == TW'(HOLD_MAX - 1)) begin
              st       <= S_ARMED;
              hold_cnt <= '0;
              qual_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + TW'(1);
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neck_judge_multi.sv
// Bench for neck_judge_multi: directed scenarios plus a randomized run checked
// against a sample-sequence model of qualification and cut termination.
module tb_neck_judge_multi;

  localparam int unsigned DW       = 13;
  localparam int unsigned TW       = 8;
  localparam int unsigned QUAL_N   = 3;
  localparam int unsigned CUT_MAX  = 10;
  localparam int unsigned MIN_CUT  = 3;
  localparam int unsigned HOLD_MAX = 20;
  localparam int unsigned CW       = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctl_switch = 1'b0;
  logic en_judge = 1'b0;
  logic end_en = 1'b0;
  logic signed [DW-1:0] d1 = '0, d2 = '0, d3 = '0;
  logic signed [DW-1:0] st_d1_min = DW'(2), st_d2_min = DW'(30);
  logic signed [DW-1:0] st_d3_lo = DW'(-60), st_d3_hi = DW'(40);
  logic signed [DW-1:0] end_d1_min = DW'(30), end_d2_max = DW'(-20);
  logic power_switch, end_pulse, timeout_pulse;
  logic [1:0] state;
  logic [CW-1:0] neck_cnt;

  int errors = 0;
  int checks = 0;

  neck_judge_multi #(
    .DW(DW), .TW(TW), .QUAL_N(QUAL_N), .CUT_MAX(CUT_MAX),
    .MIN_CUT(MIN_CUT), .HOLD_MAX(HOLD_MAX), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctl_switch(ctl_switch), .en_judge(en_judge),
    .end_en(end_en), .first_order_data(d1), .second_order_data(d2),
    .third_order_data(d3), .st_d1_min(st_d1_min), .st_d2_min(st_d2_min),
    .st_d3_lo(st_d3_lo), .st_d3_hi(st_d3_hi), .end_d1_min(end_d1_min),
    .end_d2_max(end_d2_max), .power_switch(power_switch), .state(state),
    .neck_cnt(neck_cnt), .end_pulse(end_pulse), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules, written straight from the threshold definitions.
  function automatic bit start_ok(input int a, input int b, input int c);
    return a > 2 && b > 30 && c > -60 && c < 40;
  endfunction
  function automatic bit end_ok(input int a, input int b);
    return a > 30 && b < -20;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input bit e, input int a, input int b, input int c);
    en_judge = e;
    d1 = DW'(a);
    d2 = DW'(b);
    d3 = DW'(c);
    tick();
  endtask

  // Waits (bounded) for ARMED, then feeds QUAL_N start samples.
  task automatic start_cut();
    int n;
    n = 0;
    while (state != 2'b01 && n < 100) begin
      smp(0, 0, 0, 0);
      n++;
    end
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL start_cut_arm: state=%b required 01", state);
    end
    for (int i = 0; i < int'(QUAL_N); i++) smp(1, 5, 40, 0);
    en_judge = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ctl_switch = 1'b0;
    en_judge = 1'b1;
    d1 = DW'(5); d2 = DW'(40); d3 = DW'(0);
    #22;
    rst_n = 1'b1;
    repeat (4) smp(1, 5, 40, 0);
    checks++;
    if (power_switch !== 1'b0) begin errors++; $display("FAIL reset_power: got %b want 0", power_switch); end
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
    checks++;
    if (neck_cnt !== '0) begin errors++; $display("FAIL reset_neck: got %0d want 0", neck_cnt); end
    checks++;
    if ({end_pulse, timeout_pulse} !== 2'b00) begin
      errors++; $display("FAIL reset_pulses: got %b want 00", {end_pulse, timeout_pulse});
    end
  endtask

  task automatic test_qualify();
    ctl_switch = 1'b1;
    smp(0, 0, 0, 0);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL qual_armed: got %b want 01", state); end
    smp(1, 5, 40, 0);
    smp(1, 5, 40, 0);
    smp(1, 5, 20, 0);
    checks++;
    if (power_switch !== 1'b0 || state !== 2'b01) begin
      errors++; $display("FAIL qual_broken_run: power=%b state=%b want 0/01", power_switch, state);
    end
    smp(1, 5, 40, 0);
    smp(1, 5, 40, 0);
    checks++;
    if (power_switch !== 1'b0) begin errors++; $display("FAIL qual_two_of_three: power=%b want 0", power_switch); end
    smp(1, 5, 40, 0);
    en_judge = 1'b0;
    checks++;
    if (power_switch !== 1'b1 || state !== 2'b10) begin
      errors++; $display("FAIL qual_cut_start: power=%b state=%b want 1/10", power_switch, state);
    end
    checks++;
    if (neck_cnt !== CW'(1)) begin errors++; $display("FAIL qual_neck: got %0d want 1", neck_cnt); end
  endtask

  // End samples are present but end_en=0, so only the timeout may end the cut.
  task automatic test_timeout();
    int hi;
    end_en = 1'b0;
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      smp(1, 40, -30, 0);
      if (power_switch) hi++;
      else break;
    end
    checks++;
    if (hi != int'(CUT_MAX)) begin errors++; $display("FAIL timeout_len: got %0d want %0d", hi, CUT_MAX); end
    checks++;
    if ({end_pulse, timeout_pulse} !== 2'b01 || state !== 2'b11) begin
      errors++; $display("FAIL timeout_pulse: pulses=%b state=%b want 01/11", {end_pulse, timeout_pulse}, state);
    end
    smp(0, 0, 0, 0);
    checks++;
    if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: got %b want 0", timeout_pulse); end
  endtask

  task automatic test_holdoff(input int seen);
    int hold, bad, n;
    hold = seen;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      smp(1, 5, 40, 0);
      if (power_switch) bad++;
      if (state == 2'b11) hold++;
      else break;
    end
    checks++;
    if (hold != int'(HOLD_MAX) || state !== 2'b01) begin
      errors++; $display("FAIL holdoff_len: got %0d state=%b want %0d/01", hold, state, HOLD_MAX);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL holdoff_no_cut: power high %0d cycles want 0", bad); end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      smp(1, 5, 40, 0);
      n++;
      if (power_switch) break;
    end
    en_judge = 1'b0;
    checks++;
    if (n != int'(QUAL_N) || neck_cnt !== CW'(2)) begin
      errors++; $display("FAIL rearm_cut: samples=%0d neck=%0d want %0d/2", n, neck_cnt, QUAL_N);
    end
  endtask

  // Continues the cut opened by test_holdoff.
  task automatic test_early_end();
    int hi;
    end_en = 1'b1;
    hi = 1;
    smp(0, 40, -30, 0); hi += int'(power_switch);
    smp(1, 40, -30, 0); hi += int'(power_switch);
    checks++;
    if (power_switch !== 1'b1 || end_pulse !== 1'b0) begin
      errors++; $display("FAIL early_before_min: power=%b end=%b want 1/0", power_switch, end_pulse);
    end
    smp(1, 5, 40, 0);    hi += int'(power_switch);
    smp(1, 40, -10, 0);  hi += int'(power_switch);
    smp(1, 40, -30, 0);  hi += int'(power_switch);
    en_judge = 1'b0;
    checks++;
    if ({end_pulse, timeout_pulse} !== 2'b10 || state !== 2'b11 || power_switch !== 1'b0) begin
      errors++; $display("FAIL early_end: pulses=%b state=%b power=%b want 10/11/0",
                         {end_pulse, timeout_pulse}, state, power_switch);
    end
    checks++;
    if (hi != 5) begin errors++; $display("FAIL early_len: got %0d want 5", hi); end
  endtask

  task automatic test_end_timeout_tie();
    int hi;
    end_en = 1'b1;
    start_cut();
    hi = int'(power_switch);
    for (int k = 0; k < int'(CUT_MAX); k++) begin
      smp(k == int'(CUT_MAX) - 1, 40, -30, 0);
      hi += int'(power_switch);
    end
    en_judge = 1'b0;
    checks++;
    if ({end_pulse, timeout_pulse} !== 2'b10 || hi != int'(CUT_MAX)) begin
      errors++; $display("FAIL tie_end_wins: pulses=%b len=%0d want 10/%0d", {end_pulse, timeout_pulse}, hi, CUT_MAX);
    end
    checks++;
    if (neck_cnt !== CW'(3)) begin errors++; $display("FAIL tie_neck: got %0d want 3", neck_cnt); end
  endtask

  task automatic test_override();
    end_en = 1'b0;
    start_cut();
    repeat (3) smp(0, 0, 0, 0);
    ctl_switch = 1'b0;
    smp(0, 0, 0, 0);
    checks++;
    if (state !== 2'b00 || power_switch !== 1'b0) begin
      errors++; $display("FAIL override_idle: state=%b power=%b want 00/0", state, power_switch);
    end
    checks++;
    if ({end_pulse, timeout_pulse} !== 2'b00 || neck_cnt !== CW'(4)) begin
      errors++; $display("FAIL override_hold: pulses=%b neck=%0d want 00/4", {end_pulse, timeout_pulse}, neck_cnt);
    end
    ctl_switch = 1'b1;
    smp(0, 0, 0, 0);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL override_rearm: got %b want 01", state); end
  endtask

  task automatic test_async_reset();
    start_cut();
    checks++;
    if (power_switch !== 1'b1 || neck_cnt !== CW'(5)) begin
      errors++; $display("FAIL async_precut: power=%b neck=%0d want 1/5", power_switch, neck_cnt);
    end
    smp(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (power_switch !== 1'b0 || neck_cnt !== '0 || state !== 2'b00) begin
      errors++; $display("FAIL async_reset: power=%b neck=%0d state=%b want 0/0/00", power_switch, neck_cnt, state);
    end
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // Random samples; the model tracks the run of valid start samples and the
  // first admissible end edge, and enough cuts occur to saturate neck_cnt.
  task automatic test_random();
    int run, exp_neck, a, b, c, n;
    bit e, ee, cut, fin, hit, to;
    exp_neck = 0;
    ctl_switch = 1'b1;
    for (int r = 0; r < 10; r++) begin
      n = 0;
      while (state != 2'b01 && n < 100) begin
        smp(0, 0, 0, 0);
        n++;
      end
      run = 0;
      cut = 0;
      for (int i = 0; i < 100 && !cut; i++) begin
        e = ($urandom % 4) != 0;
        a = $urandom_range(12, 0);
        b = $urandom_range(60, 25);
        c = int'($urandom_range(120, 0)) - 70;
        if (i >= 80) begin e = 1; a = 5; b = 40; c = 0; end
        if (e) begin
          if (start_ok(a, b, c)) run++;
          else run = 0;
          if (run == int'(QUAL_N)) cut = 1;
        end
        smp(e, a, b, c);
        checks++;
        if (power_switch !== cut) begin
          errors++; $display("FAIL rnd_start r%0d i%0d: power=%b want %b", r, i, power_switch, cut);
        end
      end
      if (exp_neck < (1 << CW) - 1) exp_neck++;
      checks++;
      if (neck_cnt !== CW'(exp_neck)) begin
        errors++; $display("FAIL rnd_neck r%0d: got %0d want %0d", r, neck_cnt, exp_neck);
      end
      fin = 0;
      for (int k = 0; k < int'(CUT_MAX) && !fin; k++) begin
        e = $urandom % 2;
        ee = ($urandom % 4) != 0;
        a = $urandom_range(45, 20);
        b = -int'($urandom_range(35, 5));
        c = 0;
        end_en = ee;
        hit = e && ee && end_ok(a, b) && k >= int'(MIN_CUT) - 1;
        to = k == int'(CUT_MAX) - 1;
        fin = hit || to;
        smp(e, a, b, c);
        checks++;
        if (power_switch !== !fin || {end_pulse, timeout_pulse} !== {hit, to && !hit}) begin
          errors++; $display("FAIL rnd_cut r%0d k%0d: power=%b pulses=%b want %b/%b%b",
                             r, k, power_switch, {end_pulse, timeout_pulse}, !fin, hit, to && !hit);
        end
      end
      en_judge = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_timeout();
    test_holdoff(2);
    test_early_end();
    test_end_timeout_tie();
    test_override();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
